ifu_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder. Keeps the fetch PC, issues word

---
 rtl/ifu_fetch_if.sv | 38 +++
 rtl/ifu_fetch.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Signal bundle between the fetch stage and its neighbours: redirect input,
// instruction-memory request/response port and the decode-side handshake.
interface ifu_fetch_if #(
  parameter int XLEN       = 64,
  parameter int INST_WIDTH = 32
);
  logic                  redirect_valid_i;
  logic [XLEN-1:0]       redirect_pc_i;
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [XLEN-1:0]       imem_req_addr_o;
  logic                  imem_rsp_valid_i;
  logic [INST_WIDTH-1:0] imem_rsp_data_i;
  logic                  imem_rsp_err_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [INST_WIDTH-1:0] inst_o;
  logic [XLEN-1:0]       pc_o;
  logic [1:0]            fetch_err_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i,
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output inst_valid_o, inst_o, pc_o, fetch_err_o,
    input  inst_ready_i
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i,
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  inst_valid_o, inst_o, pc_o, fetch_err_o,
    output inst_ready_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: single-outstanding word fetcher feeding a small
// instruction FIFO toward decode, with redirect flush and stale-response squash.
module ifu_fetch #(
  parameter int              XLEN       = 64,
  parameter int              INST_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  ifu_fetch_if.master bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_e;

  typedef struct packed {
    logic [1:0]            err;
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t          fifo_q [FIFO_DEPTH];
  entry_t          fifo_d [FIFO_DEPTH];

  logic   redir;
  logic   slot_free;
  logic   aligned;
  logic   req_valid;
  logic   req_fire;
  logic   inst_valid;
  logic   pop;
  logic   push;
  entry_t push_entry;

  assign redir      = bus.redirect_valid_i;
  assign slot_free  = count_q < DEPTH_C;
  assign aligned    = fetch_pc_q[1:0] == 2'b00;
  // Masked during reset and redirect so no request ever targets a dead PC.
  assign req_valid  = !rst_i && (state_q == S_REQ) && slot_free && aligned && !redir;
  assign req_fire   = req_valid && bus.imem_req_ready_i;
  assign inst_valid = (count_q != '0) && !redir;
  assign pop        = inst_valid && bus.inst_ready_i;

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = fetch_pc_q;
  assign bus.inst_valid_o     = inst_valid;
  assign bus.inst_o           = fifo_q[rd_ptr_q].inst;
  assign bus.pc_o             = fifo_q[rd_ptr_q].pc;
  assign bus.fetch_err_o      = fifo_q[rd_ptr_q].err;

  // Fetch control
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    push_entry = '0;

    if (redir) begin
      fetch_pc_d = bus.redirect_pc_i;
      unique case (state_q)
        S_REQ:  state_d = S_REQ;
        // A response arriving with the redirect settles the debt; otherwise it is still owed.
        S_WAIT: state_d = bus.imem_rsp_valid_i ? S_REQ : S_DROP;
        S_DROP: state_d = bus.imem_rsp_valid_i ? S_REQ : S_DROP;
        S_HALT: state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = S_WAIT;
          end else if (slot_free && !aligned) begin
            push       = 1'b1;
            push_entry = '{err: 2'b01, pc: fetch_pc_q, inst: NOP};
            state_d    = S_HALT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid_i) begin
            push       = 1'b1;
            push_entry = '{err: {bus.imem_rsp_err_i, 1'b0}, pc: req_pc_q,
                           inst: bus.imem_rsp_data_i};
            state_d    = bus.imem_rsp_err_i ? S_HALT : S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_rsp_valid_i) state_d = S_REQ;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Instruction buffer bookkeeping
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = push_entry;

    if (redir) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  // Single-outstanding accounting guarantees a free slot for every push.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (slot_free || pop));

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rsp_valid_i |-> (state_q == S_WAIT || state_q == S_DROP));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: queue-based reference model of the fetch
// stream plus directed scenarios pinned by hand-computed values.
module tb_ifu_fetch;
  localparam int          XLEN  = 64;
  localparam int          IW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  typedef struct packed {
    logic [1:0]  err;
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef enum {M_IDLE, M_OUT, M_STALE, M_HALT} mmode_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if #(.XLEN(XLEN), .INST_WIDTH(IW)) bus ();

  ifu_fetch #(.XLEN(XLEN), .INST_WIDTH(IW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus knobs
  int          p_ready = 100, p_iready = 100, p_redir = 0, p_err = 0;
  int          lat_lo = 0, lat_hi = 0;
  bit          err_en = 0;
  logic [63:0] err_addr = '0;
  bit          force_redir = 0;
  logic [63:0] force_pc = '0;
  bit          rst_req = 1;

  // memory model
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  // reference model
  ent_t        mq[$];
  logic [63:0] m_pc = RPC;
  logic [63:0] m_req_pc = '0;
  mmode_t      m_mode = M_IDLE;

  logic [63:0] hs_log[$];
  ent_t        pop_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [63:0] hs_at(input int i);
    return (i < hs_log.size()) ? hs_log[i] : '1;
  endfunction

  function automatic ent_t pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : '1;
  endfunction

  task automatic check_and_step();
    bit   redir, exp_rv, exp_iv, free, rspv, rspe, hs;
    ent_t e;
    if (rst) begin
      chk("rst_req_valid",  bus.imem_req_valid_o, 0);
      chk("rst_req_addr",   bus.imem_req_addr_o, RPC);
      chk("rst_inst_valid", bus.inst_valid_o, 0);
      chk("rst_outputs",    {bus.inst_o, bus.pc_o, bus.fetch_err_o}, 0);
      mq.delete();
      m_pc = RPC; m_mode = M_IDLE; mem_busy = 0;
      return;
    end
    redir  = bus.redirect_valid_i;
    rspv   = bus.imem_rsp_valid_i;
    rspe   = bus.imem_rsp_err_i;
    exp_rv = (m_mode == M_IDLE) && (mq.size() < DEPTH) && (m_pc[1:0] == 2'b00) && !redir;
    exp_iv = (mq.size() != 0) && !redir;
    chk("req_valid",  bus.imem_req_valid_o, exp_rv);
    chk("req_addr",   bus.imem_req_addr_o, m_pc);
    chk("inst_valid", bus.inst_valid_o, exp_iv);
    if (exp_iv) begin
      chk("inst", bus.inst_o, mq[0].inst);
      chk("pc",   bus.pc_o, mq[0].pc);
      chk("err",  bus.fetch_err_o, mq[0].err);
    end

    // environment reacts to what the DUT actually did
    hs = bus.imem_req_valid_o && bus.imem_req_ready_i;
    if (hs) begin
      chk("one_outstanding", mem_busy, 0);
      hs_log.push_back(bus.imem_req_addr_o);
    end
    if (bus.inst_valid_o && bus.inst_ready_i)
      pop_log.push_back('{err: bus.fetch_err_o, pc: bus.pc_o, inst: bus.inst_o});
    if (rspv) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1;
      mem_addr = bus.imem_req_addr_o;
      mem_cnt  = int'($urandom_range(lat_hi, lat_lo));
    end

    // model advance
    free = mq.size() < DEPTH;
    if (redir) begin
      mq.delete();
      m_pc = bus.redirect_pc_i;
      case (m_mode)
        M_OUT, M_STALE: m_mode = rspv ? M_IDLE : M_STALE;
        default:        m_mode = M_IDLE;
      endcase
    end else begin
      if (exp_iv && bus.inst_ready_i) void'(mq.pop_front());
      case (m_mode)
        M_IDLE:
          if (exp_rv && bus.imem_req_ready_i) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 64'd4;
            m_mode   = M_OUT;
          end else if (free && m_pc[1:0] != 2'b00) begin
            e = '{err: 2'b01, pc: m_pc, inst: 32'h0000_0013};
            mq.push_back(e);
            m_mode = M_HALT;
          end
        M_OUT:
          if (rspv) begin
            e = '{err: {rspe, 1'b0}, pc: m_req_pc, inst: bus.imem_rsp_data_i};
            mq.push_back(e);
            m_mode = rspe ? M_HALT : M_IDLE;
          end
        M_STALE: if (rspv) m_mode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    logic [63:0] rpc;
    @(posedge clk);
    #1;
    rst = rst_req;
    if (rst_req) mem_busy = 0;
    bus.imem_req_ready_i = ($urandom % 100) < p_ready;
    bus.inst_ready_i     = ($urandom % 100) < p_iready;
    bus.imem_rsp_valid_i = mem_busy && (mem_cnt == 0);
    bus.imem_rsp_data_i  = mem_busy ? data_of(mem_addr) : $urandom;
    bus.imem_rsp_err_i   = (err_en && mem_busy && mem_addr == err_addr) ||
                           (($urandom % 1000) < p_err);
    if (rst_req) begin
      bus.redirect_valid_i = 0;
      bus.redirect_pc_i    = '0;
    end else if (force_redir) begin
      bus.redirect_valid_i = 1;
      bus.redirect_pc_i    = force_pc;
      force_redir          = 0;
    end else if (($urandom % 100) < p_redir) begin
      rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
      if ($urandom % 16 == 0) rpc[1] = 1'b1;
      if ($urandom % 8 == 0)  rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      bus.redirect_valid_i = 1;
      bus.redirect_pc_i    = rpc;
    end else begin
      bus.redirect_valid_i = 0;
      bus.redirect_pc_i    = {$urandom, $urandom};
    end
    @(negedge clk);
    check_and_step();
  endtask

  task automatic do_reset(input int n);
    rst_req = 1;
    repeat (n) cycle();
    rst_req = 0;
  endtask

  task automatic clear_logs();
    hs_log.delete();
    pop_log.delete();
  endtask

  initial begin
    bit seen;
    bus.redirect_valid_i = 0; bus.redirect_pc_i = '0;
    bus.imem_req_ready_i = 0; bus.imem_rsp_valid_i = 0;
    bus.imem_rsp_data_i = '0; bus.imem_rsp_err_i = 0; bus.inst_ready_i = 0;

    // 1: streaming fetch from reset
    do_reset(2); clear_logs();
    repeat (10) cycle();
    chk("s1_req0", hs_at(0), 64'h8000_0000);
    chk("s1_req1", hs_at(1), 64'h8000_0004);
    chk("s1_req2", hs_at(2), 64'h8000_0008);
    chk("s1_pop0_pc", pop_at(0).pc, 64'h8000_0000);
    chk("s1_pop1_pc", pop_at(1).pc, 64'h8000_0004);
    chk("s1_pop0_inst", pop_at(0).inst, 32'h5EAD_BEEF);
    chk("s1_throughput", pop_log.size() >= 4, 1);

    // 2: decode stalled fills the buffer and stops requests
    do_reset(2); clear_logs(); p_iready = 0;
    repeat (12) cycle();
    chk("s2_hs_count", hs_log.size(), DEPTH);
    chk("s2_req_held", bus.imem_req_valid_o, 0);
    chk("s2_head_pc", bus.pc_o, RPC);
    p_iready = 100; cycle(); p_iready = 0;
    chk("s2_pop_pc", pop_at(0).pc, RPC);
    repeat (4) cycle();
    chk("s2_next_req", hs_at(2), RPC + 64'd8);

    // 3: redirect while waiting on a slow response
    do_reset(2); clear_logs(); p_iready = 100; lat_lo = 2; lat_hi = 2;
    cycle();
    force_redir = 1; force_pc = 64'h8000_0100;
    repeat (11) cycle();
    chk("s3_req1", hs_at(1), 64'h8000_0100);
    seen = 0;
    foreach (pop_log[i]) if (pop_log[i].pc == RPC) seen = 1;
    chk("s3_no_stale", seen, 0);
    chk("s3_first_pop", pop_at(0).pc, 64'h8000_0100);

    // 4: redirect coincident with the response
    do_reset(2); clear_logs(); lat_lo = 0; lat_hi = 0;
    cycle();
    force_redir = 1; force_pc = 64'h8000_0100;
    cycle();
    cycle();
    chk("s4_addr", bus.imem_req_addr_o, 64'h8000_0100);
    chk("s4_req_valid", bus.imem_req_valid_o, 1);
    chk("s4_empty", bus.inst_valid_o, 0);
    repeat (6) cycle();
    chk("s4_first_pop", pop_at(0).pc, 64'h8000_0100);

    // 5: misaligned redirect produces a fault entry and halts
    do_reset(2); clear_logs(); p_iready = 0;
    force_redir = 1; force_pc = 64'h8000_0102;
    repeat (4) cycle();
    chk("s5_valid", bus.inst_valid_o, 1);
    chk("s5_pc", bus.pc_o, 64'h8000_0102);
    chk("s5_err", bus.fetch_err_o, 2'b01);
    chk("s5_inst", bus.inst_o, 32'h0000_0013);
    chk("s5_no_req", hs_log.size(), 0);
    force_redir = 1; force_pc = 64'h8000_0200; p_iready = 100;
    repeat (5) cycle();
    chk("s5_resume", hs_at(0), 64'h8000_0200);

    // 6: access fault halts; reset mid-WAIT restarts at RESET_PC
    do_reset(2); clear_logs(); err_en = 1; err_addr = RPC + 64'd4;
    repeat (10) cycle();
    err_en = 0;
    chk("s6_hs_count", hs_log.size(), 2);
    chk("s6_err_pc", pop_at(1).pc, RPC + 64'd4);
    chk("s6_err_code", pop_at(1).err, 2'b10);
    force_redir = 1; force_pc = 64'h8000_0300; lat_lo = 3; lat_hi = 3;
    repeat (3) cycle();
    chk("s6_wait_req", hs_log[hs_log.size()-1], 64'h8000_0300);
    do_reset(1); clear_logs(); lat_lo = 0; lat_hi = 0;
    repeat (3) cycle();
    chk("s6_after_rst", hs_at(0), RPC);

    // 7: randomized traffic
    p_ready = 70; p_iready = 60; p_redir = 4; p_err = 30; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 500 == 0) do_reset(1);
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
